csd_decoder: RTL and testbench

Reverse path of the binary-to-CSD converter: accepts one packed canonical-signed-digit (CSD) word and serially reconstructs its two's-complement binary value, one digit per clock, MSB first. It sits after the CSD buffer read port: the controller fetches a word and pulses `start`, then collects `dataOut` and the status flags when `done` fires. It also checks the word for illegal digit codes, non-canonical adjacency and out-of-range results.

---
 rtl/csd_pkg.sv | 22 ++
 rtl/csd_digit_decode.sv | 32 +++
 rtl/csd_decoder.sv | 121 ++++++++++++
 tb/tb_csd_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/csd_pkg.sv
// CSD decoder shared definitions: digit codes, FSM states, digit-count helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csd_pkg;

  localparam logic [1:0] CSD_ZERO = 2'b00;
  localparam logic [1:0] CSD_POS  = 2'b01;
  localparam logic [1:0] CSD_NEG  = 2'b11;
  localparam logic [1:0] CSD_BAD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A W-bit binary value needs W+1 CSD digits.
  function automatic int csd_ndig(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/csd_digit_decode.sv
// Maps one 2-bit CSD code to a signed digit value plus nonzero/illegal flags.
// Latency: combinational.
// Backpressure: none.
module csd_digit_decode
  import csd_pkg::*;
(
  input  logic        [1:0] code,
  output logic signed [1:0] val,
  output logic              nz,
  output logic              bad
);

  // Illegal code 10 contributes zero and is only flagged.
  always_comb begin
    val = 2'sb00;
    nz  = 1'b0;
    bad = 1'b0;
    case (code)
      CSD_POS: begin
        val = 2'sb01;
        nz  = 1'b1;
      end
      CSD_NEG: begin
        val = 2'sb11;
        nz  = 1'b1;
      end
      CSD_BAD: bad = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/csd_decoder.sv
// Serial CSD-to-binary decoder, one digit per clock MSB first, with canonicity/code/range checks.
// Latency: done pulses N+1 edges after the accepting edge; outputs load one edge earlier.
// Backpressure: start is taken only in IDLE; starts during RUN/DONE are dropped, not queued.
module csd_decoder
  import csd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2*csd_ndig(W)-1:0] csdIn,
  output logic [W-1:0]             dataOut,
  output logic                     busy,
  output logic                     done,
  output logic                     Zout,
  output logic                     ovf,
  output logic                     errNc,
  output logic                     errCode
);

  localparam int N  = csd_ndig(W);
  localparam int AW = W + 2;
  localparam int CW = $clog2(N);

  state_t               state;
  logic [2*N-1:0]       sr;
  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] acc;
  logic                 prev_nz;
  logic                 nc_s;
  logic                 bad_s;

  logic signed [1:0]    dval;
  logic                 dnz;
  logic                 dbad;
  logic signed [AW-1:0] acc_nxt;
  logic                 nc_nxt;
  logic                 bad_nxt;
  logic                 ovf_nxt;
  logic [2:0]           acc_top;

  csd_digit_decode u_dig (
    .code (sr[2*N-1 -: 2]),
    .val  (dval),
    .nz   (dnz),
    .bad  (dbad)
  );

  // Next accumulator and sticky error terms for the digit at the head of the shift register.
  always_comb begin
    acc_nxt = (acc <<< 1) + $signed({{W{dval[1]}}, dval});
    nc_nxt  = nc_s | (dnz & prev_nz);
    bad_nxt = bad_s | dbad;
    // In range for W bits iff the top three accumulator bits are all equal.
    acc_top = acc_nxt[AW-1:W-1];
    ovf_nxt = !((acc_top == 3'b000) || (acc_top == 3'b111));
  end

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      sr      <= '0;
      cnt     <= '0;
      acc     <= '0;
      prev_nz <= 1'b0;
      nc_s    <= 1'b0;
      bad_s   <= 1'b0;
      dataOut <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Zout    <= 1'b0;
      ovf     <= 1'b0;
      errNc   <= 1'b0;
      errCode <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sr      <= csdIn;
            cnt     <= '0;
            acc     <= '0;
            prev_nz <= 1'b0;
            nc_s    <= 1'b0;
            bad_s   <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc     <= acc_nxt;
          sr      <= {sr[2*N-3:0], 2'b00};
          cnt     <= cnt + 1'b1;
          prev_nz <= dnz;
          nc_s    <= nc_nxt;
          bad_s   <= bad_nxt;
          if (cnt == CW'(N - 1)) begin
            dataOut <= acc_nxt[W-1:0];
            Zout    <= (acc_nxt == '0);
            ovf     <= ovf_nxt;
            errNc   <= nc_nxt;
            errCode <= bad_nxt;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csd_decoder.sv
// Directed-vector bench for csd_decoder with W=8 (9 digits).
// Latency: checks done at 10 edges after acceptance.
// Backpressure: exercises starts ignored during RUN/DONE.
`timescale 1ns/1ps
module tb_csd_decoder;

  localparam int W = 8;
  localparam int N = 9;

  typedef int dig_t [9];

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [2*N-1:0]   csdIn = '0;
  logic [W-1:0]     dataOut;
  logic             busy;
  logic             done;
  logic             Zout;
  logic             ovf;
  logic             errNc;
  logic             errCode;

  int nchk = 0;
  int nerr = 0;

  csd_decoder #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .csdIn   (csdIn),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done),
    .Zout    (Zout),
    .ovf     (ovf),
    .errNc   (errNc),
    .errCode (errCode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Digits listed d8..d0; 2 stands for the illegal code 10.
  function automatic logic [2*N-1:0] enc(input dig_t d);
    logic [2*N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      case (d[i])
        0:       w[2*(N-1-i) +: 2] = 2'b00;
        1:       w[2*(N-1-i) +: 2] = 2'b01;
        -1:      w[2*(N-1-i) +: 2] = 2'b11;
        default: w[2*(N-1-i) +: 2] = 2'b10;
      endcase
    end
    return w;
  endfunction

  // Launch one decode and wait (bounded) for done; lat = edges after acceptance.
  task automatic run_word(input logic [2*N-1:0] w, output int lat);
    @(negedge clk);
    csdIn = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_flags(input string tag, input logic [7:0] d, input logic z,
                             input logic o, input logic nc, input logic bc);
    chk({tag, "_data"}, dataOut, d);
    chk({tag, "_zout"}, Zout, z);
    chk({tag, "_ovf"}, ovf, o);
    chk({tag, "_errnc"}, errNc, nc);
    chk({tag, "_errcode"}, errCode, bc);
  endtask

  initial begin
    int lat;
    int ndone;
    int first_done;

    // Reset state
    #12;
    check_flags("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // 8 - 1 = 7
    run_word(enc('{0, 0, 0, 0, 0, 1, 0, 0, -1}), lat);
    chk("t1_latency", lat, 10);
    chk("t1_busy_at_done", busy, 1'b0);
    check_flags("t1", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("t1_done_one_cycle", done, 1'b0);

    // -128 fits, 255 does not
    run_word(enc('{0, -1, 0, 0, 0, 0, 0, 0, 0}), lat);
    check_flags("t2a", 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    run_word(enc('{1, 0, 0, 0, 0, 0, 0, 0, -1}), lat);
    check_flags("t2b", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);

    // Adjacent nonzero digits, then all-zero clears sticky errNc
    run_word(enc('{0, 0, 0, 0, 0, 0, 0, 1, 1}), lat);
    check_flags("t3a", 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    run_word(enc('{0, 0, 0, 0, 0, 0, 0, 0, 0}), lat);
    check_flags("t3b", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Illegal code at digit 2 counts as zero
    run_word(enc('{0, 0, 0, 0, 0, 0, 2, 0, 1}), lat);
    check_flags("t4", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);

    // Starts during RUN (cycle 3) and DONE (cycle 9) must be ignored
    @(negedge clk);
    csdIn = enc('{0, 0, 0, 0, 0, 0, 1, 0, 1});
    start = 1'b1;
    ndone = 0;
    first_done = -1;
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      start = (c == 3 || c == 9);
      if (c == 0) csdIn = enc('{-1, 0, -1, 0, -1, 0, -1, 0, -1});
    end
    chk("t5_done_count", ndone, 1);
    chk("t5_done_edge", first_done, 10);
    check_flags("t5", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in RUN cycle 5: outputs clear, no done
    @(negedge clk);
    csdIn = enc('{0, 0, 0, 0, 0, 0, 1, 1, 1});
    start = 1'b1;
    ndone = 0;
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) ndone++;
    end
    reset = 1'b0;
    #1;
    check_flags("t6_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (c == 2) reset = 1'b1;
    end
    chk("t6_no_done", ndone, 0);
    run_word(enc('{0, 0, 0, 0, 0, 1, 0, 0, -1}), lat);
    chk("t6_latency", lat, 10);
    check_flags("t6_after", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
